sipo_decoder: RTL
=================

# sipo_decoder

Serial-in/parallel-out receive stage for the encoder's PISO output. It reassembles the LSB-first serial stream into WIDTH-bit words, aligned by an upstream frame-start marker. Completed words go to the downstream consumer over a valid/ready handshake through a single holding register. Overrun and framing faults are flagged instead of silently corrupting data.

## Interface
- WIDTH, 8, word width in bits; must be ≥ 2.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- serialIn  in  1  serial data bit, LSB of each word first.
- bitValid  in  1  serialIn carries a valid bit this cycle.
- frameStart  in  1  the current valid bit is bit 0 of a word; ignored unless bitValid=1.
- message  out  WIDTH  holding-register word; stable while messageValid=1.
- messageValid  out  1  holding register full.
- messageReady  in  1  consumer accepts; transfer when messageValid & messageReady.
- overrun  out  1  sticky: a completed word was dropped because the holding register was full.
- framingError  out  1  one-cycle pulse: frameStart arrived mid-word and the partial word was discarded.
- clearOverrun  in  1  synchronous clear of overrun.

## Operation
- FSM states: HUNT, SHIFT.
  - HUNT: valid bits are ignored until bitValid & frameStart. That bit is stored at position 0, bitCount=1, and the FSM enters SHIFT.
  - SHIFT: each valid bit is stored at position bitCount, then bitCount increments.
    - When the WIDTH-th bit is stored, the word is complete and bitCount returns to 0.
    - The FSM stays in SHIFT; the next valid bit is bit 0 of the next word, and frameStart on it is optional.
  - SHIFT + bitValid & frameStart with bitCount≠0: discard the partial word, pulse framingError, store the bit as bit 0, set bitCount=1.
- Shift register shifts right (new bit enters at MSB), so after WIDTH bits bit 0 sits at message[0].
- Completion while the holding register is empty, or being emptied this cycle (messageValid & messageReady): load the holding register and set messageValid next cycle.
- Completion while the holding register is full and not being emptied:
  - Drop the new word and set overrun.
  - message keeps its old value.
- Transfer with no completion: messageValid falls next cycle.
- Completion in the same cycle as clearOverrun, with an overrun condition: the set wins.
- bitValid=0 cycles stall the shift; there is no timeout.

## Timing
- Reset values:
  - message=0, messageValid=0, overrun=0, framingError=0.
  - FSM=HUNT, bitCount=0.
- Latency: the clock edge that samples the WIDTH-th valid bit makes message/messageValid visible in the following cycle (1 cycle).
- Throughput: one word per WIDTH valid-bit cycles, with zero bubbles, provided messageReady is held high.
- A back-to-back transfer and completion in the same cycle keeps messageValid high with the new word, without a gap.
- message must not change while messageValid=1 and messageReady=0.
- framingError is registered and high for exactly the one cycle after the offending bit is sampled.
- Reset asserted mid-word or with messageValid=1: everything clears immediately, and the pending word is lost.
- After reset deasserts, the block needs a new frameStart before it captures any data.

## Structure
- Package sipo_pkg:
  - state typedef (HUNT, SHIFT).
  - default WIDTH constant.
  - COUNT_W = $clog2(WIDTH+1).
- Sub-module sipo_bit_counter:
  - Counts valid bits 0..WIDTH-1.
  - Inputs: enable, sync load-to-1.
  - Output: wordDone strobe.
- The top level holds the FSM, shift register, holding register and flags.

## Test plan
- Reset, then frameStart + 8 valid bits of 0xA5 sent LSB first (1,0,1,0,0,1,0,1) with messageReady=1 -> message=0xA5 and messageValid=1 for one cycle, appearing one cycle after the 8th bit.
- Bits with no frameStart after reset -> messageValid stays 0. A later frameStart followed by 0x3C -> exactly one word, 0x3C.
- Continuous stream 0x01, 0x80, 0xFF with messageReady=1 and no idle cycles -> three words in order; messageValid stays high across the 0x80→0xFF boundary with no gap.
- messageReady=0 while 0x11 and then 0x22 arrive -> message stays 0x11, 0x22 is dropped, and overrun=1 stays set. After clearOverrun -> overrun=0.
- frameStart after 3 bits of a word, followed by 0x5A -> framingError pulses once and the next word is 0x5A.
- Reset asserted mid-word, with 0xC3 pending and messageValid=1 -> all outputs 0, FSM=HUNT, and no spurious word afterwards.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the SIPO receive stage.
package sipo_pkg;

   typedef enum logic {
      HUNT  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 8;
   localparam int COUNT_W = $clog2(DEFAULT_WIDTH + 1);

   function automatic int count_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit position counter for the SIPO stage; wraps to 0 on the last bit
// of a word and strobes word_done in that same cycle.
module sipo_bit_counter
   import sipo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   localparam int CW = count_w(WIDTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   input  logic          load,
   output logic [CW-1:0] count,
   output logic          word_done
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   assign word_done = enable & ~load & (count == LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= CW'(1);
      end else if (enable) begin
         count <= word_done ? '0 : count + CW'(1);
      end
   end

endmodule

// File: rtl/sipo_decoder.sv
// Serial-in/parallel-out receiver: frame alignment, LSB-first word
// assembly and a single holding register toward the consumer.
module sipo_decoder
   import sipo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             serialIn,
   input  logic             bitValid,
   input  logic             frameStart,
   output logic [WIDTH-1:0] message,
   output logic             messageValid,
   input  logic             messageReady,
   output logic             overrun,
   output logic             framingError,
   input  logic             clearOverrun
);

   localparam int CW = count_w(WIDTH);

   state_t state_q;
   state_t state_d;

   logic             take;
   logic             cnt_en;
   logic             cnt_load;
   logic             fe_d;
   logic [CW-1:0]    count;
   logic             word_done;
   logic             block;
   logic [WIDTH-2:0] shreg;
   logic [WIDTH-1:0] word_next;

   sipo_bit_counter #(
      .WIDTH(WIDTH)
   ) u_cnt (
      .clock(clock),
      .reset(reset),
      .enable(cnt_en),
      .load(cnt_load),
      .count(count),
      .word_done(word_done)
   );

   // The completing bit enters at the MSB, so the finished word is
   // the incoming bit concatenated with the upper stored bits.
   assign word_next = {serialIn, shreg};
   assign block     = messageValid & ~messageReady;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      take     = 1'b0;
      cnt_en   = 1'b0;
      cnt_load = 1'b0;
      fe_d     = 1'b0;
      unique case (state_q)
         HUNT: begin
            if (bitValid & frameStart) begin
               take     = 1'b1;
               cnt_load = 1'b1;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (bitValid) begin
               take = 1'b1;
               if (frameStart) begin
                  cnt_load = 1'b1;
                  fe_d     = (count != '0);
               end else begin
                  cnt_en = 1'b1;
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shreg <= '0;
      end else if (take) begin
         shreg <= word_next[WIDTH-1:1];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         message      <= '0;
         messageValid <= 1'b0;
      end else if (word_done & ~block) begin
         message      <= word_next;
         messageValid <= 1'b1;
      end else if (messageValid & messageReady) begin
         messageValid <= 1'b0;
      end
   end

   // A drop in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overrun      <= 1'b0;
         framingError <= 1'b0;
      end else begin
         framingError <= fe_d;
         if (word_done & block) begin
            overrun <= 1'b1;
         end else if (clearOverrun) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule
